// File: rtl/crbar2_unswap.sv
// Receiving end of the 2-lane crossbar: restores lane order using the applied
// select bit and buffers pairs in a small FIFO. Optional: CRBAR2_SWAP_COUNT_EN.
module crbar2_unswap #(
  parameter int Q     = 15,
  parameter int N     = 32,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_y1,
  input  logic [N-1:0] in_y2,
  input  logic         in_s,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_x1,
  output logic [N-1:0] out_x2,
  output logic [15:0]  swap_count
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [2*N-1:0] mem [DEPTH];
  logic [2*N-1:0] last_pair;
  logic [2*N-1:0] pair_out;
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic           push;
  logic           pop;
  logic           q_unused;

  // Q only documents the fixed-point format; data passes untouched.
  assign q_unused = (Q >= 0);

  assign in_ready  = (count < CW'(DEPTH));
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // When empty, present the last popped pair rather than the stale slot at rd_ptr.
  assign pair_out = out_valid ? mem[rd_ptr] : last_pair;
  assign out_x1   = pair_out[2*N-1:N];
  assign out_x2   = pair_out[N-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
      last_pair <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_s ? {in_y2, in_y1} : {in_y1, in_y2};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        last_pair <= mem[rd_ptr];
        rd_ptr    <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

`ifdef CRBAR2_SWAP_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      swap_count <= '0;
    end else if (push && in_s && (swap_count != 16'hFFFF)) begin
      swap_count <= swap_count + 1'b1;
    end
  end
`else
  assign swap_count = '0;
`endif

endmodule

// File: tb/tb_crbar2_unswap.sv
// Scoreboard bench for crbar2_unswap: driver queues expected pairs on accept,
// monitor pops and compares on each output handshake.
module tb_crbar2_unswap;

  logic        clk;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_y1;
  logic [31:0] in_y2;
  logic        in_s;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_x1;
  logic [31:0] out_x2;
  logic [15:0] swap_count;

  logic [63:0] exp_q [$];
  int tests;
  int fails;
  int exp_swaps;

  crbar2_unswap #(.Q(15), .N(32), .DEPTH(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_y1      (in_y1),
    .in_y2      (in_y2),
    .in_s       (in_s),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_x1     (out_x1),
    .out_x2     (out_x2),
    .swap_count (swap_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] exp_count();
`ifdef CRBAR2_SWAP_COUNT_EN
    return 16'(exp_swaps);
`else
    return 16'h0000;
`endif
  endfunction

  // Drive one pair; e1/e2 are the hand-computed restored lanes.
  task automatic push(input logic [31:0] y1, input logic [31:0] y2, input logic s,
                      input logic [31:0] e1, input logic [31:0] e2);
    logic rdy;
    logic ok;
    ok       = 1'b0;
    in_valid = 1'b1;
    in_y1    = y1;
    in_y2    = y2;
    in_s     = s;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      if (rdy) ok = 1'b1;
    end
    if (ok) begin
      exp_q.push_back({e1, e2});
      if (s) exp_swaps++;
    end else begin
      tests++;
      fails++;
      $display("FAIL push_timeout: got no accept expected accept within 50 cycles");
    end
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 50 && exp_q.size() != 0; c++) @(posedge clk);
    #1;
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Monitor: compares every pair leaving the FIFO against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_pair: got %h_%h expected no pair", out_x1, out_x2);
        end else begin
          logic [63:0] e;
          e = exp_q.pop_front();
          check("out_x1", out_x1, e[63:32]);
          check("out_x2", out_x2, e[31:0]);
        end
      end
    end
  end

  initial begin
    tests     = 0;
    fails     = 0;
    exp_swaps = 0;
    reset     = 1'b1;
    in_valid  = 1'b0;
    in_y1     = '0;
    in_y2     = '0;
    in_s      = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // Reset then idle
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_x1", out_x1, 32'h0);
    check("rst_out_x2", out_x2, 32'h0);
    check("rst_swap_count", 32'(swap_count), 32'h0);

    // Swapped and straight pairs, first-word latency of one cycle
    @(posedge clk); #1;
    out_ready = 1'b1;
    push(32'h00200000, 32'h00180000, 1'b1, 32'h00180000, 32'h00200000);
    check("lat_out_valid", 32'(out_valid), 32'd1);
    check("lat_out_x1", out_x1, 32'h00180000);
    check("lat_out_x2", out_x2, 32'h00200000);
    push(32'h00200000, 32'h00180000, 1'b0, 32'h00200000, 32'h00180000);
    drain();
    @(negedge clk);
    check("empty_hold_x1", out_x1, 32'h00200000);
    check("empty_hold_x2", out_x2, 32'h00180000);

    // Backpressure: fill, stall third pair, then release
    @(posedge clk); #1;
    out_ready = 1'b0;
    fork
      begin
        push(32'h11110001, 32'h22220001, 1'b1, 32'h22220001, 32'h11110001);
        push(32'h33330002, 32'h44440002, 1'b0, 32'h33330002, 32'h44440002);
        push(32'h55550003, 32'h66660003, 1'b1, 32'h66660003, 32'h55550003);
      end
      begin
        repeat (2) @(posedge clk);
        repeat (3) begin
          @(negedge clk);
          check("full_in_ready", 32'(in_ready), 32'd0);
          check("full_hold_x1", out_x1, 32'h22220001);
          check("full_hold_x2", out_x2, 32'h11110001);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("pre_pop_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("post_pop_in_ready", 32'(in_ready), 32'd1);
      end
    join
    drain();

    // Streaming with alternating select
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      logic        s;
      a = 32'h10000000 + 32'(i);
      b = 32'h20000000 + 32'(i);
      s = (i % 2 == 0);
      push(a, b, s, s ? b : a, s ? a : b);
      check("stream_count1", 32'(out_valid && in_ready), 32'd1);
    end
    drain();
    check("swap_count", 32'(swap_count), 32'(exp_count()));

    // Reset while two pairs are buffered
    @(posedge clk); #1;
    out_ready = 1'b0;
    push(32'hAAAA0001, 32'hBBBB0001, 1'b0, 32'hAAAA0001, 32'hBBBB0001);
    push(32'hCCCC0002, 32'hDDDD0002, 1'b1, 32'hDDDD0002, 32'hCCCC0002);
    check("pre_rst_in_ready", 32'(in_ready), 32'd0);
    #2 reset = 1'b1;
    #1;
    check("async_out_valid", 32'(out_valid), 32'd0);
    check("async_in_ready", 32'(in_ready), 32'd1);
    check("async_out_x1", out_x1, 32'h0);
    check("async_swap_count", 32'(swap_count), 32'h0);
    exp_q.delete();
    exp_swaps = 0;
    @(posedge clk); #1;
    reset     = 1'b0;
    out_ready = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_out_valid", 32'(out_valid), 32'd0);
    end
    @(posedge clk); #1;
    push(32'h0000ABCD, 32'h00001234, 1'b1, 32'h00001234, 32'h0000ABCD);
    drain();
    check("final_swap_count", 32'(swap_count), 32'(exp_count()));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/crbar2_unswap.md
Name: crbar2_unswap

Overview:
- Receiving end of the 2-lane crossbar path in the CNN datapath.
- Accepts lane pairs that were swapped (or not) by an upstream 2x2 crossbar, together with the select bit that was applied.
- Restores original lane order (x1, x2) and buffers the pairs in a small FIFO with valid/ready handshake on both sides.
- Sits between the crossbar output and the downstream fixed-point MAC/pooling stage.

Parameters:
- Q, 15, fractional bits of the fixed-point words; carried for interface consistency, no arithmetic on data.
- N, 32, word width of each lane.
- DEPTH, 2, FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- in_valid  input  1  upstream pair valid
- in_ready  output  1  block can accept a pair this cycle
- in_y1  input  N  crossbar lane 1 output
- in_y2  input  N  crossbar lane 2 output
- in_s  input  1  select applied upstream (1 = lanes were swapped)
- out_valid  output  1  restored pair available
- out_ready  input  1  downstream accepts pair
- out_x1  output  N  restored original lane 1
- out_x2  output  N  restored original lane 2
- swap_count  output  16  swapped pairs accepted (only with SWAP_COUNT_EN)

Behaviour:
- Reset (async, immediate): FIFO empty, wr_ptr = rd_ptr = 0, count = 0, out_valid = 0, out_x1 = out_x2 = 0, in_ready = 1, swap_count = 0. Reset mid-transfer discards all buffered pairs; no partial pair survives.
- Unswap on write:
  - in_s = 0: store (in_y1, in_y2).
  - in_s = 1: store (in_y2, in_y1).
  - Data bits pass unmodified; Q does not affect storage.
- Push: occurs when in_valid && in_ready at the clock edge.
- Pop: occurs when out_valid && out_ready at the clock edge.
- in_ready = (count < DEPTH), combinational from registered count only; no combinational path from out_ready.
- out_valid = (count > 0). out_x1/out_x2 driven from entry[rd_ptr]. Output data holds stable while out_valid && !out_ready.
- Latency: a pair pushed at edge k is visible on out_* after edge k (first-word latency 1 cycle when empty). No bypass.
- Count and pointer updates:
  - Push only: count+1, wr_ptr+1.
  - Pop only: count-1, rd_ptr+1.
  - Push and pop in the same cycle (count between 1 and DEPTH-1): count unchanged, both pointers advance.
- Full (count = DEPTH): in_ready = 0. A same-cycle pop frees a slot; push becomes possible from the next cycle.
- Empty (count = 0): out_valid = 0, out_ready is ignored, out_x1/out_x2 hold the last popped values (0 after reset).
- Pointers wrap modulo DEPTH. Ordering is strict FIFO.
- in_valid with in_s = X is a protocol violation and is not checked.

Optional Feature:
- Macro: CRBAR2_SWAP_COUNT_EN.
- Defined: swap_count increments by 1 on each push with in_s = 1, saturates at 16'hFFFF, and is cleared only by reset.
- Undefined: swap_count port is tied to 16'h0000 with no counter logic; port list is unchanged.

Test Plan:
- Reset then idle: out_valid = 0, in_ready = 1, out_x1 = out_x2 = 0, swap_count = 0.
- Push y1 = 32'h00200000, y2 = 32'h00180000, s = 1, with out_ready = 1 -> next cycle out_valid = 1, out_x1 = 32'h00180000, out_x2 = 32'h00200000.
- Push the same words with s = 0 -> out_x1 = 32'h00200000, out_x2 = 32'h00180000.
- out_ready = 0, push 3 pairs back-to-back -> in_ready drops after the 2nd push, 3rd pair is held off, output stays on the 1st pair. Raise out_ready -> pairs emerge in order and in_ready returns 1 cycle after the first pop.
- Continuous push and pop with alternating s for 10 pairs, out_ready = 1 -> one pair per cycle, all correctly unswapped, count steady at 1. With the macro defined, swap_count = 5.
- Assert reset while 2 pairs are buffered -> out_valid = 0 and in_ready = 1 immediately (asynchronously). No stale pair appears after reset release.
